// File: rtl/avmm_sector_arbiter.sv
// Round-robin arbiter sharing one NoC AVMM slave port among N_M partial-reconfiguration sector masters.
// One command per grant, one transaction in flight; reads that never complete return DEADBEEF after RD_TIMEOUT cycles.
module avmm_sector_arbiter #(
  parameter int N_M        = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_M-1:0]    m_read,
  input  logic [N_M-1:0]    m_write,
  input  logic [20*N_M-1:0] m_address,
  input  logic [32*N_M-1:0] m_writedata,
  input  logic [N_M-1:0]    freeze,
  output logic [N_M-1:0]    m_waitrequest,
  output logic [N_M-1:0]    m_readdatavalid,
  output logic [31:0]       m_readdata,
  output logic [19:0]       s_address,
  output logic [31:0]       s_writedata,
  output logic              s_read,
  output logic              s_write,
  input  logic              s_waitrequest,
  input  logic [31:0]       s_readdata,
  input  logic              s_readdatavalid,
  output logic [1:0]        grant_id,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  state_t       state, state_nxt;
  logic [1:0]   rr_ptr, rr_nxt, gid_nxt, pick;
  logic [7:0]   cnt, cnt_nxt;
  logic         err_nxt, found;
  logic [N_M-1:0] req;
  logic         g_rd, g_wr, g_frz, timeout;
  int           arb_idx;

  assign req     = (m_read | m_write) & ~freeze;
  assign g_rd    = m_read[grant_id];
  assign g_wr    = m_write[grant_id];
  assign g_frz   = freeze[grant_id];
  assign timeout = (cnt == 8'(RD_TIMEOUT));

  // Search starts just after the last served master, so it gets lowest priority next.
  always_comb begin
    pick    = '0;
    found   = 1'b0;
    arb_idx = 0;
    for (int k = 1; k <= N_M; k++) begin
      arb_idx = (int'(rr_ptr) + k) % N_M;
      if (!found && req[arb_idx]) begin
        found = 1'b1;
        pick  = 2'(arb_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 2'(N_M - 1);
      grant_id    <= '0;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      grant_id    <= gid_nxt;
      cnt         <= cnt_nxt;
      err_timeout <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    gid_nxt   = grant_id;
    cnt_nxt   = cnt;
    err_nxt   = err_timeout;
    case (state)
      IDLE: begin
        if (found) begin
          gid_nxt   = pick;
          state_nxt = CMD;
        end
      end
      CMD: begin
        // A frozen or withdrawn master forfeits its grant without touching the slave.
        if (g_frz || !(g_rd || g_wr)) begin
          rr_nxt    = grant_id;
          state_nxt = IDLE;
        end else if (!s_waitrequest) begin
          if (g_wr) begin
            rr_nxt    = grant_id;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        if (s_readdatavalid || timeout) begin
          rr_nxt    = grant_id;
          state_nxt = IDLE;
          if (!s_readdatavalid) err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_read          = 1'b0;
    s_write         = 1'b0;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    m_readdata      = '0;
    s_address       = m_address[20*grant_id +: 20];
    s_writedata     = m_writedata[32*grant_id +: 32];
    case (state)
      CMD: begin
        s_write                 = g_wr & ~g_frz;
        s_read                  = g_rd & ~g_wr & ~g_frz;
        m_waitrequest[grant_id] = s_waitrequest;
      end
      RDWAIT: begin
        if (!g_frz && (s_readdatavalid || timeout)) begin
          m_readdatavalid[grant_id] = 1'b1;
          m_readdata                = s_readdatavalid ? s_readdata : 32'hDEADBEEF;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_avmm_sector_arbiter.sv
// Bench for avmm_sector_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_avmm_sector_arbiter;
  localparam int N  = 4;
  localparam int TO = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_read, m_write, freeze, m_waitrequest, m_readdatavalid;
  logic [20*N-1:0] m_address;
  logic [32*N-1:0] m_writedata;
  logic [31:0]     m_readdata, s_writedata, s_readdata;
  logic [19:0]     s_address;
  logic            s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [1:0]      grant_id;
  logic            err_timeout;

  avmm_sector_arbiter #(.N_M(N), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .freeze(freeze), .m_waitrequest(m_waitrequest),
    .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata), .s_address(s_address),
    .s_writedata(s_writedata), .s_read(s_read), .s_write(s_write),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: which master owns the port, whether its read is awaiting data.
  int cur, last, gidm, waited;
  bit pend, errm;
  logic [N-1:0] e_wait, e_rdv, acc;
  logic [31:0]  e_rdata;
  bit e_sw, e_sr;

  // Slave emulation and observation
  int sl_cnt, sl_lat, stray_en, rdv_seen;
  bit sl_out, hold;
  int rdv_cnt [N];
  int gq[$];
  logic [N-1:0] last_rdv;
  logic [31:0]  last_rdata;

  task automatic model_reset();
    cur = -1; last = N - 1; gidm = 0; waited = 0; pend = 0; errm = 0;
  endtask

  task automatic compare();
    bit in_cmd;
    if (rst) model_reset();
    in_cmd = (cur >= 0) && !pend;
    e_sw = 0; e_sr = 0; e_wait = '1; e_rdv = '0; e_rdata = '0;
    if (in_cmd) begin
      e_sw = m_write[cur] && !freeze[cur];
      e_sr = m_read[cur] && !m_write[cur] && !freeze[cur];
      if (!s_waitrequest) e_wait[cur] = 1'b0;
    end
    if (cur >= 0 && pend && !freeze[cur]) begin
      if (s_readdatavalid) begin e_rdv[cur] = 1'b1; e_rdata = s_readdata; end
      else if (waited == TO) begin e_rdv[cur] = 1'b1; e_rdata = 32'hDEADBEEF; end
    end
    chk("s_write", s_write, e_sw);
    chk("s_read", s_read, e_sr);
    chk("m_waitrequest", m_waitrequest, e_wait);
    chk("m_readdatavalid", m_readdatavalid, e_rdv);
    chk("m_readdata", m_readdata, e_rdata);
    chk("grant_id", grant_id, gidm);
    chk("err_timeout", err_timeout, errm);
    if (e_sw || e_sr) chk("s_address", s_address, m_address[20*cur +: 20]);
    if (e_sw) chk("s_writedata", s_writedata, m_writedata[32*cur +: 32]);
  endtask

  task automatic model_step();
    if (rst) begin model_reset(); return; end
    if (cur < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last + k) % N;
        if ((m_read[i] || m_write[i]) && !freeze[i]) begin
          cur = i; gidm = i; pend = 0;
          break;
        end
      end
    end else if (!pend) begin
      if (freeze[cur] || !(m_read[cur] || m_write[cur])) begin last = cur; cur = -1; end
      else if (!s_waitrequest) begin
        if (e_sw) begin last = cur; cur = -1; end
        else begin pend = 1; waited = 0; end
      end
    end else if (s_readdatavalid || waited == TO) begin
      if (!s_readdatavalid) errm = 1;
      last = cur; cur = -1;
    end else begin
      waited++;
    end
  endtask

  task automatic slave_update();
    if (s_readdatavalid && sl_out && sl_cnt == 0) sl_out = 0;
    if (e_sr && !s_waitrequest) begin
      sl_out = 1;
      sl_cnt = (sl_lat == -2) ? int'($urandom_range(4)) : sl_lat;
    end else if (sl_out && sl_cnt > 0) begin
      sl_cnt--;
    end
    s_readdata      = $urandom;
    s_readdatavalid = (sl_out && sl_cnt == 0 && sl_lat != -1) || (stray_en == 1) ||
                      (stray_en == 2 && $urandom_range(15) == 0);
  endtask

  task automatic step();
    #2;
    compare();
    if (s_write || s_read) gq.push_back(int'(grant_id));
    if (|m_readdatavalid) begin
      rdv_seen++;
      last_rdv   = m_readdatavalid;
      last_rdata = m_readdata;
      for (int i = 0; i < N; i++) if (m_readdatavalid[i]) rdv_cnt[i]++;
    end
    acc = ~e_wait & (m_read | m_write) & ~freeze;
    @(posedge clk);
    #1;
    model_step();
    slave_update();
    if (!hold) begin
      m_read  = m_read & ~acc;
      m_write = m_write & ~acc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_read = '0; m_write = '0; freeze = '0;
    step();
    rst = 1'b0;
    gq.delete();
    rdv_seen = 0;
    for (int i = 0; i < N; i++) rdv_cnt[i] = 0;
  endtask

  task automatic rand_masters();
    for (int i = 0; i < N; i++) begin
      if (!(m_read[i] || m_write[i])) begin
        if ($urandom_range(3) == 0) begin
          int r;
          r = int'($urandom_range(2));
          m_read[i]  = (r != 1);
          m_write[i] = (r != 0);
          m_address[20*i +: 20]   = 20'($urandom);
          m_writedata[32*i +: 32] = $urandom;
        end
      end else if ($urandom_range(31) == 0) begin
        m_read[i] = 1'b0; m_write[i] = 1'b0;
      end
      if ($urandom_range(39) == 0) freeze[i] = ~freeze[i];
    end
    s_waitrequest = ($urandom_range(2) == 0);
    rst = ($urandom_range(399) == 0);
  endtask

  initial begin
    int c;
    m_read = '0; m_write = '0; freeze = '0;
    m_address = '0; m_writedata = '0;
    for (int i = 0; i < N; i++) begin
      m_address[20*i +: 20]   = 20'h100 * 20'(i + 1);
      m_writedata[32*i +: 32] = 32'hA000_0000 + 32'(i);
    end
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0; rst = 1'b1;
    model_reset();
    sl_out = 0; sl_cnt = 0; sl_lat = 1; stray_en = 0; hold = 0; acc = '0;
    #1;
    step();
    do_reset();

    // Masters 0 and 2 write together: 0 first, then 2.
    m_write = 4'b0101;
    step();
    chk("first_grant_id", grant_id, 0);
    for (int k = 0; k < 6; k++) step();
    chk("wr_count", gq.size(), 2);
    chk("wr_seq0", gq[0], 0);
    chk("wr_seq1", gq[1], 2);

    // All masters read continuously, slave answers two cycles after acceptance.
    do_reset();
    hold = 1; sl_lat = 2; m_read = 4'b1111;
    for (c = 0; c < 80 && gq.size() < 5; c++) step();
    chk("rr_len_ok", gq.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_seq%0d", i), gq[i], i % N);
    for (int i = 0; i < N; i++) chk($sformatf("rr_rdv%0d", i), rdv_cnt[i], 1);
    hold = 0;

    // Master 1 read never answered: timeout response.
    do_reset();
    sl_lat = -1; m_read = 4'b0010;
    for (c = 1; c <= 300 && rdv_seen == 0; c++) step();
    chk("to_cycle", c - 1, 258);
    chk("to_rdv", last_rdv, 4'b0010);
    chk("to_data", last_rdata, 32'hDEADBEEF);
    chk("to_err", err_timeout, 1);
    stray_en = 1;
    for (int k = 0; k < 10; k++) step();
    chk("stray_ignored", rdv_seen, 1);
    stray_en = 0;

    // Master 3 frozen while stalled in CMD; master 0 granted next.
    do_reset();
    sl_lat = 1; s_waitrequest = 1'b1; m_write = 4'b1000;
    step();
    chk("frz_grant", grant_id, 3);
    freeze = 4'b1000; m_write = 4'b1001;
    step();
    s_waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("frz_wr_count", gq.size(), 1);
    chk("frz_next", gq[0], 0);
    freeze = '0;

    // Reset while a read waits for data.
    do_reset();
    sl_lat = -1; m_read = 4'b0100;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1; m_read = '0;
    #2;
    chk("rst_wait", m_waitrequest, 4'hF);
    chk("rst_rdv", m_readdatavalid, 0);
    chk("rst_sread", s_read, 0);
    #1;
    step();
    rst = 1'b0; gq.delete(); sl_lat = 1;
    m_write = 4'b0110;
    for (int k = 0; k < 6; k++) step();
    chk("post_rst_seq0", gq[0], 1);
    chk("post_rst_seq1", gq[1], 2);

    // Randomized traffic.
    do_reset();
    sl_lat = -2; stray_en = 2;
    for (int k = 0; k < 3000; k++) begin
      rand_masters();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/avmm_sector_arbiter.md
AVMM_SECTOR_ARBITER -- requirements
Module: avmm_sector_arbiter

Interface
REQ-001 SHALL have parameter N_M, default 4: number of PR sector masters sharing one NoC AVMM slave port.
REQ-002 SHALL have parameter RD_TIMEOUT, default 255: read-response timeout in cycles, 8-bit counter.
REQ-003 SHALL have port clk  in  1  sole clock.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port m_read, m_write  in  N_M each  per-master AVMM commands.
REQ-006 SHALL have port m_address  in  20*N_M  per-master address, master i at [20i+19:20i].
REQ-007 SHALL have port m_writedata  in  32*N_M  per-master write data, master i at [32i+31:32i].
REQ-008 SHALL have port freeze  in  N_M  master i is under partial reconfiguration; its inputs are invalid.
REQ-009 SHALL have port m_waitrequest  out  N_M  per-master waitrequest.
REQ-010 SHALL have port m_readdatavalid  out  N_M  per-master read-response strobe.
REQ-011 SHALL have port m_readdata  out  32  read data broadcast to all masters.
REQ-012 SHALL have ports s_address out 20, s_writedata out 32, s_read out 1, s_write out 1: shared slave-side command.
REQ-013 SHALL have ports s_waitrequest in 1, s_readdata in 32, s_readdatavalid in 1: shared slave-side response.
REQ-014 SHALL have port grant_id  out  2  index of the current or last granted master.
REQ-015 SHALL have port err_timeout  out  1  sticky read-timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, CMD, RDWAIT.
REQ-017 IDLE: req = (m_read | m_write) & ~freeze; if req is nonzero, SHALL grant the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_M, register grant_id, and enter CMD next cycle.
REQ-018 Latency SHALL be one cycle: a request sampled in IDLE at cycle t appears on s_read/s_write at t+1.
REQ-019 In CMD, s_address and s_writedata SHALL mux from master grant_id combinationally. s_write = m_write[g] & ~freeze[g]. s_read = m_read[g] & ~m_write[g] & ~freeze[g], so write wins if both are set.
REQ-020 Outside CMD, s_read and s_write SHALL be 0.
REQ-021 m_waitrequest[i] SHALL be 0 only when state==CMD, i==grant_id, and s_waitrequest==0; it SHALL be 1 in all other cases.
REQ-022 CMD, accepted write (s_write & ~s_waitrequest): SHALL set rr_ptr=grant_id and go to IDLE.
REQ-023 CMD, accepted read: SHALL clear the timeout counter and go to RDWAIT.
REQ-024 CMD, freeze[grant_id]=1 or the command deasserted before acceptance: SHALL go to IDLE with no slave command, and set rr_ptr=grant_id.
REQ-025 RDWAIT, s_readdatavalid=1: m_readdata=s_readdata and m_readdatavalid[grant_id]=1 combinationally for that cycle, unless freeze[grant_id]=1, which discards the response. SHALL set rr_ptr=grant_id and go to IDLE.
REQ-026 RDWAIT, no valid: counter SHALL increment each cycle.
REQ-027 RDWAIT, counter==RD_TIMEOUT: SHALL pulse m_readdatavalid[grant_id] with m_readdata=32'hDEADBEEF (suppressed if frozen), set err_timeout, set rr_ptr=grant_id, and go to IDLE.
REQ-028 s_readdatavalid outside RDWAIT (late or stray) SHALL be ignored; no m_readdatavalid.
REQ-029 At most one slave transaction SHALL be outstanding at any time.
REQ-030 m_readdata SHALL be 0 when no m_readdatavalid bit is set.
REQ-031 No new grant SHALL occur in the cycle the FSM returns to IDLE; arbitration occurs in IDLE only.

Reset
REQ-032 rst=1 SHALL asynchronously force: state=IDLE, rr_ptr=N_M-1 (master 0 has first priority), grant_id=0, counter=0, err_timeout=0.
REQ-033 While in reset, all outputs SHALL be: s_read=0, s_write=0, m_waitrequest=all 1, m_readdatavalid=0.
REQ-034 Reset during CMD or RDWAIT SHALL abandon the transaction; a response arriving after reset SHALL be ignored per REQ-028.

Verification
REQ-035 Masters 0 and 2 write simultaneously after reset, s_waitrequest=0 -> master 0 is granted first (s_write at cycle 1), then master 2; grant_id sequence 0,2.
REQ-036 All four masters hold m_read continuously, slave returns data 2 cycles after acceptance -> grants rotate 0,1,2,3,0. Each m_readdatavalid[i] pulses once, with the matching s_readdata.
REQ-037 Master 1 reads and the slave never returns valid -> after 255 RDWAIT cycles, m_readdatavalid[1]=1, m_readdata=32'hDEADBEEF, err_timeout=1. A later stray s_readdatavalid produces no output.
REQ-038 Master 3 is granted, freeze[3] rises in CMD while s_waitrequest=1 -> s_write never asserts, the FSM returns to IDLE, and master 0's pending request is granted next.
REQ-039 rst pulses while in RDWAIT -> m_readdatavalid stays 0, m_waitrequest is all 1, and the next request is granted normally from master 0 priority.
